multi_lane_tu_mapper: RTL and testbench

//  Parametrised next-generation active-symbol mapper for the DP main-link transmit path.
//  - Builds transfer units (TUs) on LANES lanes in lockstep, instead of following an externally supplied per-cycle stream state.
//  - Each TU is data symbols followed by stuffing framed by FS/FE control symbols. The data-symbol count comes from the scheduler.
//  - Sits between the lane steering stage and the per-lane scrambler/encoder.

---
 rtl/multi_lane_tu_mapper_pkg.sv | 15 +
 rtl/multi_lane_tu_mapper_tu_slot_counter.sv | 78 +++++++
 rtl/multi_lane_tu_mapper.sv | 102 ++++++++++
 tb/tb_multi_lane_tu_mapper.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/multi_lane_tu_mapper_pkg.sv
// Symbol constants and TU slot types shared by the TU mapper and its slot counter.
package dp_sym_pkg;

  localparam logic [7:0] SYM_FS   = 8'hFC;
  localparam logic [7:0] SYM_FE   = 8'hFE;
  localparam logic [7:0] SYM_FILL = 8'h00;

  typedef enum logic [1:0] {
    TU_DATA,
    TU_FS,
    TU_FILL,
    TU_FE
  } tu_state_t;

endpackage

// File: rtl/multi_lane_tu_mapper_tu_slot_counter.sv
// Slot counter, per-TU valid-count latch and slot-type FSM for one transfer unit.
// The type of the current slot is presented combinationally so that the lane
// muxes can register the matching symbol on the next enabled edge.
module tu_slot_counter
  import dp_sym_pkg::*;
#(
  parameter int TU_SIZE = 64,
  parameter int CNT_W   = $clog2(TU_SIZE + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tu_valid_count,
  output tu_state_t        o_slot_type,
  output logic             o_tu_start
);

  localparam logic [CNT_W-1:0] TU_N    = CNT_W'(TU_SIZE);
  localparam logic [CNT_W-1:0] TU_LAST = CNT_W'(TU_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [CNT_W-1:0] r_slot;
  logic [CNT_W-1:0] r_vc;
  tu_state_t        r_state;

  logic [CNT_W-1:0] w_vc;
  logic [CNT_W-1:0] w_stuff;
  logic [CNT_W-1:0] w_slot_inc;
  tu_state_t        w_type;
  tu_state_t        w_next_state;

  // Data count saturates at the TU length before any subtraction.
  function automatic logic [CNT_W-1:0] sat_vc(input logic [CNT_W-1:0] v);
    return (v > TU_N) ? TU_N : v;
  endfunction

  // Current slot type and next FSM state; slot 0 uses the freshly sampled count.
  always_comb begin
    w_vc         = (r_slot == '0) ? sat_vc(i_tu_valid_count) : r_vc;
    w_stuff      = TU_N - w_vc;
    w_slot_inc   = r_slot + ONE;
    w_type       = r_state;
    w_next_state = r_state;
    if (r_slot == '0) begin
      w_type = (w_vc == '0) ? TU_FS : TU_DATA;
    end
    case (w_type)
      TU_DATA: begin
        if (r_slot == TU_LAST)                            w_next_state = TU_DATA;
        else if (w_slot_inc == w_vc && w_stuff >= TWO)    w_next_state = TU_FS;
        else if (w_slot_inc == w_vc && w_stuff == ONE)    w_next_state = TU_FE;
        else                                              w_next_state = TU_DATA;
      end
      TU_FS:   w_next_state = (w_stuff > TWO) ? TU_FILL : TU_FE;
      TU_FILL: w_next_state = (w_slot_inc == TU_LAST) ? TU_FE : TU_FILL;
      TU_FE:   w_next_state = TU_DATA;
      default: w_next_state = TU_DATA;
    endcase
  end

  // Counter, count latch and state advance only on enabled slots.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot  <= '0;
      r_vc    <= '0;
      r_state <= TU_DATA;
    end else if (i_en) begin
      r_slot  <= (r_slot == TU_LAST) ? '0 : w_slot_inc;
      r_vc    <= w_vc;
      r_state <= w_next_state;
    end
  end

  assign o_slot_type = w_type;
  assign o_tu_start  = (r_slot == '0);

endmodule

// File: rtl/multi_lane_tu_mapper.sv
// Multi-lane TU mapper: frames steered data into transfer units of data,
// FS/fill/FE stuffing, identical slot type on every lane, one-cycle latency.
module multi_lane_tu_mapper
  import dp_sym_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int SYM_W   = 8,
  parameter int TU_SIZE = 64,
  parameter int CNT_W   = $clog2(TU_SIZE + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sched_stream_en,
  input  logic [CNT_W-1:0]       tu_valid_count,
  input  logic [LANES*SYM_W-1:0] main_steered,
  input  logic                   main_valid,
  output logic                   am_data_ready,
  output logic [LANES*SYM_W-1:0] am_active_symbol,
  output logic [LANES-1:0]       am_control_sym_flag,
  output logic                   am_tu_start,
  output logic                   am_underflow,
  input  logic                   underflow_clr
);

  tu_state_t w_slot_type;
  logic      w_tu_start_p0;
  logic      r_tu_start_p1;
  logic      r_underflow;

  tu_slot_counter #(
    .TU_SIZE(TU_SIZE),
    .CNT_W  (CNT_W)
  ) u_slot_counter (
    .clk             (clk),
    .rst             (rst),
    .i_en            (sched_stream_en),
    .i_tu_valid_count(tu_valid_count),
    .o_slot_type     (w_slot_type),
    .o_tu_start      (w_tu_start_p0)
  );

  assign am_data_ready = sched_stream_en && (w_slot_type == TU_DATA);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [SYM_W-1:0] w_sym_p0;
    logic             w_flag_p0;
    logic [SYM_W-1:0] r_sym_p1;
    logic             r_flag_p1;

    // Lane symbol select; a starved data slot sends the fill symbol.
    always_comb begin
      w_sym_p0  = SYM_W'(SYM_FILL);
      w_flag_p0 = 1'b0;
      case (w_slot_type)
        TU_DATA: w_sym_p0 = main_valid ? main_steered[g*SYM_W +: SYM_W] : SYM_W'(SYM_FILL);
        TU_FS: begin
          w_sym_p0  = SYM_W'(SYM_FS);
          w_flag_p0 = 1'b1;
        end
        TU_FE: begin
          w_sym_p0  = SYM_W'(SYM_FE);
          w_flag_p0 = 1'b1;
        end
        default: begin
          w_sym_p0  = SYM_W'(SYM_FILL);
          w_flag_p0 = 1'b0;
        end
      endcase
    end

    // p0 -> p1: lane output register, held while the scheduler stalls.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_sym_p1  <= '0;
        r_flag_p1 <= 1'b0;
      end else if (sched_stream_en) begin
        r_sym_p1  <= w_sym_p0;
        r_flag_p1 <= w_flag_p0;
      end
    end

    assign am_active_symbol[g*SYM_W +: SYM_W] = r_sym_p1;
    assign am_control_sym_flag[g]             = r_flag_p1;
  end

  // p0 -> p1: TU start marker travels with the slot-0 symbols.
  always_ff @(posedge clk) begin
    if (rst)                  r_tu_start_p1 <= 1'b0;
    else if (sched_stream_en) r_tu_start_p1 <= w_tu_start_p0;
  end

  // Sticky underflow; a new underflow beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst)                                                          r_underflow <= 1'b0;
    else if (sched_stream_en && w_slot_type == TU_DATA && !main_valid) r_underflow <= 1'b1;
    else if (underflow_clr)                                           r_underflow <= 1'b0;
  end

  assign am_tu_start  = r_tu_start_p1;
  assign am_underflow = r_underflow;

endmodule

// File: tb/tb_multi_lane_tu_mapper.sv
module tb_multi_lane_tu_mapper;

  localparam int LANES   = 4;
  localparam int SYM_W   = 8;
  localparam int TU_SIZE = 64;
  localparam int CNT_W   = $clog2(TU_SIZE + 1);
  localparam int W       = LANES * SYM_W;

  typedef enum {K_DATA, K_FS, K_FILL, K_FE} kind_t;

  logic             clk;
  logic             rst;
  logic             sched_stream_en;
  logic [CNT_W-1:0] tu_valid_count;
  logic [W-1:0]     main_steered;
  logic             main_valid;
  logic             am_data_ready;
  logic [W-1:0]     am_active_symbol;
  logic [LANES-1:0] am_control_sym_flag;
  logic             am_tu_start;
  logic             am_underflow;
  logic             underflow_clr;

  int           checks;
  int           failures;
  int           ready_cnt;
  int           m_k;
  int           m_vc;
  bit           m_uf;
  logic [W-1:0] e_sym;
  logic [LANES-1:0] e_flag;
  logic         e_start;

  multi_lane_tu_mapper #(
    .LANES  (LANES),
    .SYM_W  (SYM_W),
    .TU_SIZE(TU_SIZE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .sched_stream_en    (sched_stream_en),
    .tu_valid_count     (tu_valid_count),
    .main_steered       (main_steered),
    .main_valid         (main_valid),
    .am_data_ready      (am_data_ready),
    .am_active_symbol   (am_active_symbol),
    .am_control_sym_flag(am_control_sym_flag),
    .am_tu_start        (am_tu_start),
    .am_underflow       (am_underflow),
    .underflow_clr      (underflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slot map of a TU straight from the framing rules.
  function automatic kind_t classify(input int k, input int vc);
    if (k < vc)               return K_DATA;
    else if (k == TU_SIZE - 1) return K_FE;
    else if (k == vc)          return K_FS;
    else                       return K_FILL;
  endfunction

  function automatic logic [W-1:0] repl(input logic [7:0] s);
    logic [W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*SYM_W +: SYM_W] = s;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h at slot %0d", tag, obs, exp, m_k);
    end
  endtask

  // One symbol clock: drive, check ready, advance model, check registered outputs.
  task automatic cycle(input bit en, input bit valid, input bit clr, input bit rs);
    int           vc_eff;
    kind_t        kd;
    logic [W-1:0] data;
    @(negedge clk);
    data            = W'($urandom);
    sched_stream_en = en;
    main_valid      = valid;
    main_steered    = data;
    underflow_clr   = clr;
    rst             = rs;
    if (m_k == 0) vc_eff = (int'(tu_valid_count) > TU_SIZE) ? TU_SIZE : int'(tu_valid_count);
    else          vc_eff = m_vc;
    kd = classify(m_k, vc_eff);
    #1;
    if (!rs) begin
      chk("data_ready", 64'(am_data_ready), 64'(en && kd == K_DATA));
      if (am_data_ready) ready_cnt++;
    end
    @(posedge clk);
    #1;
    if (rs) begin
      m_k = 0; m_vc = 0; m_uf = 0;
      e_sym = '0; e_flag = '0; e_start = 1'b0;
    end else begin
      if (en) begin
        e_start = (m_k == 0);
        if (kd == K_DATA)      begin e_sym = valid ? data : '0; e_flag = '0; end
        else if (kd == K_FS)   begin e_sym = repl(8'hFC); e_flag = '1; end
        else if (kd == K_FE)   begin e_sym = repl(8'hFE); e_flag = '1; end
        else                   begin e_sym = '0; e_flag = '0; end
        m_vc = vc_eff;
        m_k  = (m_k == TU_SIZE - 1) ? 0 : m_k + 1;
      end
      if (en && kd == K_DATA && !valid) m_uf = 1'b1;
      else if (clr)                     m_uf = 1'b0;
    end
    chk("symbol", 64'(am_active_symbol), 64'(e_sym));
    chk("ctrl_flag", 64'(am_control_sym_flag), 64'(e_flag));
    chk("tu_start", 64'(am_tu_start), 64'(e_start));
    chk("underflow", 64'(am_underflow), 64'(m_uf));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_to_tu_start();
    for (int i = 0; i < TU_SIZE; i++) begin
      if (m_k == 0) break;
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    checks = 0; failures = 0; ready_cnt = 0;
    m_k = 0; m_vc = 0; m_uf = 1'b0;
    e_sym = '0; e_flag = '0; e_start = 1'b0;
    rst = 1'b1; sched_stream_en = 1'b0; main_valid = 1'b0;
    underflow_clr = 1'b0; main_steered = '0; tu_valid_count = CNT_W'(60);

    // Reset state.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // vc=60, two full TUs.
    tu_valid_count = CNT_W'(60);
    run(2 * TU_SIZE);

    // vc=63 (FE only), vc=64 and vc=70 (all data).
    tu_valid_count = CNT_W'(63); run(TU_SIZE);
    tu_valid_count = CNT_W'(64); run(TU_SIZE);
    tu_valid_count = CNT_W'(70); run(TU_SIZE);

    // vc=0: FS, fill, FE and never ready.
    tu_valid_count = CNT_W'(0);
    ready_cnt = 0;
    run(TU_SIZE);
    chk("vc0_ready_count", 64'(ready_cnt), 64'd0);

    // Stall for 5 slots in the middle of the fill region.
    tu_valid_count = CNT_W'(30);
    run(40);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run(TU_SIZE - 40);
    chk("stall_resume_slot", 64'(m_k), 64'd0);

    // Starved data slot 10, sticky flag, clear, set-beats-clear.
    tu_valid_count = CNT_W'(60);
    run(10);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    run(TU_SIZE - 11);
    run(3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run(2);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    run_to_tu_start();

    // Mid-TU count change takes effect next TU; reset aborts a TU.
    tu_valid_count = CNT_W'(60);
    run(20);
    tu_valid_count = CNT_W'(30);
    run(TU_SIZE - 20);
    run(40);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    run(TU_SIZE);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 10) tu_valid_count = CNT_W'($urandom_range(0, 70));
      cycle($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 92,
            $urandom_range(0, 99) < 5, $urandom_range(0, 299) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
